// File: rtl/aes_encrypt_iterative_if.sv
// Block handshake bundle for the iterative AES-128 core.
// Ports: request side in_valid/in_ready/in_data/in_key, response side out_valid/out_ready/out_data.
// master = requester + consumer (drives inputs, takes ciphertext); slave = the core.
interface aes_encrypt_iterative_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_encrypt_iterative.sv
// Iterative AES-128 encryption: one round per cycle, round keys expanded on the fly.
// Latency: out_valid rises 10 cycles after the accept edge; one block per 12 cycles at best.
// Backpressure: ciphertext held in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk, reset (sync, active-high), bus (slave modport: in_valid/in_ready/in_data/in_key,
//        out_valid/out_ready/out_data), busy (high while rounds execute), round (1..10 in ROUND, else 0).
module aes_encrypt_iterative (
    input  logic                         clk,
    input  logic                         reset,
    aes_encrypt_iterative_if.slave       bus,
    output logic                         busy,
    output logic [3:0]                   round
);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsmState_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    fsmState_t    fsmQ;
    logic [127:0] stateQ;
    logic [127:0] rkQ;
    logic [3:0]   cntQ;
    logic [7:0]   rconQ;
    logic         inReadyQ;
    logic         outValidQ;
    logic         busyQ;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8 * i -: 8] = sbox(s[127 - 8 * i -: 8]);
        end
        return o;
    endfunction

    // Byte i of the state sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32 * c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32 * c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32 * c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] encryptRound(input logic [127:0] s, input logic [127:0] k);
        return mixColumns(shiftRows(subBytes(s))) ^ k;
    endfunction

    function automatic logic [127:0] lastEncryptRound(input logic [127:0] s, input logic [127:0] k);
        return shiftRows(subBytes(s)) ^ k;
    endfunction

    // Key schedule step: derive the next round key from the current one.
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rotW3, subW3, tWord;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] nextRk;
    logic [127:0] midState;
    logic [127:0] lastState;

    assign {w0, w1, w2, w3} = rkQ;
    assign rotW3 = {w3[23:0], w3[31:24]};
    assign subW3 = {sbox(rotW3[31:24]), sbox(rotW3[23:16]), sbox(rotW3[15:8]), sbox(rotW3[7:0])};
    assign tWord = subW3 ^ {rconQ, 24'h000000};
    assign n0 = w0 ^ tWord;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nextRk = {n0, n1, n2, n3};

    assign midState  = encryptRound(stateQ, nextRk);
    assign lastState = lastEncryptRound(stateQ, nextRk);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsmQ      <= IDLE;
            stateQ    <= '0;
            rkQ       <= '0;
            cntQ      <= 4'd0;
            rconQ     <= 8'h01;
            inReadyQ  <= 1'b1;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
        end else begin
            case (fsmQ)
                IDLE: begin
                    if (bus.in_valid) begin
                        stateQ   <= bus.in_data ^ bus.in_key;
                        rkQ      <= bus.in_key;
                        cntQ     <= 4'd1;
                        rconQ    <= 8'h01;
                        inReadyQ <= 1'b0;
                        busyQ    <= 1'b1;
                        fsmQ     <= ROUND;
                    end
                end
                ROUND: begin
                    rkQ   <= nextRk;
                    rconQ <= xtime(rconQ);
                    if (cntQ == 4'd10) begin
                        stateQ    <= lastState;
                        cntQ      <= 4'd0;
                        busyQ     <= 1'b0;
                        outValidQ <= 1'b1;
                        fsmQ      <= DONE;
                    end else begin
                        stateQ <= midState;
                        cntQ   <= cntQ + 4'd1;
                    end
                end
                DONE: begin
                    // in_ready rises only after the handshake edge, so no same-edge accept.
                    if (bus.out_ready) begin
                        outValidQ <= 1'b0;
                        inReadyQ  <= 1'b1;
                        fsmQ      <= IDLE;
                    end
                end
                default: fsmQ <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = inReadyQ;
    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outValidQ ? stateQ : 128'd0;
    assign busy          = busyQ;
    // The counter is already 0 outside ROUND, so it doubles as the debug round number.
    assign round         = cntQ;

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
module tb_aes_encrypt_iterative;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [3:0] round;

    int compared   = 0;
    int mismatched = 0;
    int busyCycles;
    logic sawValid;

    aes_encrypt_iterative_if bus ();

    aes_encrypt_iterative dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy),
        .round (round)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
        step();
        step();

        // Reset values.
        checkBit("rst_in_ready", bus.in_ready, 1'b1);
        checkBit("rst_out_valid", bus.out_valid, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkVec("rst_round", {124'd0, round}, 128'd0);
        checkVec("rst_out_data", bus.out_data, 128'd0);
        checkVec("rst_rk", dut.rkQ, 128'd0);

        // in_valid during reset must not be accepted.
        bus.in_valid = 1'b1;
        bus.in_data  = PT_C1;
        bus.in_key   = KEY_C1;
        step();
        checkBit("rst_vs_valid_ready", bus.in_ready, 1'b1);
        checkBit("rst_vs_valid_busy", busy, 1'b0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        step();

        // C.1, inputs scrambled right after accept, exact 10-cycle latency.
        bus.in_valid = 1'b1;
        bus.in_data  = PT_C1;
        bus.in_key   = KEY_C1;
        step();
        checkBit("c1_accept_ready", bus.in_ready, 1'b0);
        checkBit("c1_accept_busy", busy, 1'b1);
        checkVec("c1_accept_round", {124'd0, round}, 128'd1);
        bus.in_valid = 1'b0;
        bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.in_key   = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i <= 10; i++) begin
            step();
            checkBit("c1_valid_timing", bus.out_valid, (i == 10));
        end
        checkVec("c1_data", bus.out_data, CT_C1);
        bus.out_ready = 1'b1;
        step();
        checkBit("c1_release_valid", bus.out_valid, 1'b0);
        checkVec("c1_release_data", bus.out_data, 128'd0);
        checkBit("c1_release_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b0;

        // Appendix B vector: round trace, final round key, 5-cycle stall.
        bus.in_valid = 1'b1;
        bus.in_data  = PT_B;
        bus.in_key   = KEY_B;
        step();
        bus.in_valid = 1'b0;
        busyCycles   = 0;
        for (int i = 1; i <= 10; i++) begin
            checkVec("b_round_trace", {124'd0, round}, 128'(i));
            if (busy) busyCycles++;
            step();
        end
        checkVec("b_busy_cycles", 128'(busyCycles), 128'd10);
        checkBit("b_busy_done", busy, 1'b0);
        checkVec("b_round_done", {124'd0, round}, 128'd0);
        checkVec("b_rk10", dut.rkQ, RK10_B);
        checkBit("b_valid", bus.out_valid, 1'b1);
        checkVec("b_data", bus.out_data, CT_B);
        for (int i = 0; i < 5; i++) begin
            step();
            checkBit("b_stall_valid", bus.out_valid, 1'b1);
            checkVec("b_stall_data", bus.out_data, CT_B);
            checkBit("b_stall_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        step();
        checkBit("b_release_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // Reset during round 5 discards the block.
        bus.in_valid = 1'b1;
        bus.in_data  = PT_C1;
        bus.in_key   = KEY_C1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checkVec("mid_round5", {124'd0, round}, 128'd5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkBit("mid_rst_ready", bus.in_ready, 1'b1);
        checkBit("mid_rst_valid", bus.out_valid, 1'b0);
        checkBit("mid_rst_busy", busy, 1'b0);
        checkVec("mid_rst_round", {124'd0, round}, 128'd0);
        checkVec("mid_rst_data", bus.out_data, 128'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.out_valid) sawValid = 1'b1;
        end
        checkBit("mid_no_valid", sawValid, 1'b0);

        // Fresh C.1 after the aborted run.
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checkBit("rerun_valid", bus.out_valid, 1'b1);
        checkVec("rerun_data", bus.out_data, CT_C1);
        bus.out_ready = 1'b1;
        step();
        checkBit("rerun_release", bus.out_valid, 1'b0);

        // Back-to-back with in_valid held and out_ready high: 12-cycle spacing.
        bus.in_valid = 1'b1;
        bus.in_data  = PT_C1;
        bus.in_key   = KEY_C1;
        step();
        bus.in_data  = PT_B;
        bus.in_key   = KEY_B;
        for (int i = 0; i < 10; i++) begin
            checkBit("b2b_ready_low", bus.in_ready, 1'b0);
            step();
        end
        checkBit("b2b_first_valid", bus.out_valid, 1'b1);
        checkVec("b2b_first_data", bus.out_data, CT_C1);
        checkBit("b2b_done_ready", bus.in_ready, 1'b0);
        step();
        checkBit("b2b_gap_ready", bus.in_ready, 1'b1);
        checkBit("b2b_gap_valid", bus.out_valid, 1'b0);
        step();
        checkBit("b2b_second_accept", bus.in_ready, 1'b0);
        checkBit("b2b_second_busy", busy, 1'b1);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checkBit("b2b_second_timing", bus.out_valid, (i == 10));
        end
        checkVec("b2b_second_data", bus.out_data, CT_B);
        step();
        checkBit("b2b_end_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
